// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: PC, imem req/ack handshake,
// fetch timeout/retry, and next-PC selection on retire.
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  input  logic                stall,
  input  logic                SaltoCond,
  input  logic                Zero,
  output logic [31:0]         instru,
  output logic [5:0]          opcode,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    RETRY
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_instru;
  logic                r_valid;
  logic                r_req;
  logic                r_err;
  logic [CW-1:0]       r_cnt;

  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_offset;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_take;
  logic                w_expired;

  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  assign w_offset   = {{(PC_WIDTH-18){r_instru[15]}},
                       r_instru[15:0], 2'b00};
  assign w_target   = w_pc_plus4 + w_offset;
  assign w_take     = SaltoCond & Zero;
  assign w_expired  = (r_cnt == CW'(TIMEOUT - 1));

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instru      = r_instru;
  assign opcode      = r_instru[31:26];
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_err   = r_err;

  // Fetch/issue FSM; req is raised one cycle after reset or retry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_instru <= '0;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_instru <= imem_data;
            r_valid  <= 1'b1;
            r_req    <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ISSUE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RETRY;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ISSUE: begin
          if (!stall) begin
            r_valid <= 1'b0;
            r_pc    <= w_take ? w_target : w_pc_plus4;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        RETRY: begin
          r_req   <= 1'b1;
          r_cnt   <= '0;
          r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle model compared every cycle,
// plus directed literal checks.
module tb_fetch_unit;

  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 0;
  logic [31:0] imem_data = 0;
  logic        stall = 1;
  logic        SaltoCond = 0;
  logic        Zero = 0;
  logic [31:0] instru;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  logic        rst1 = 1;
  logic        req1;
  logic [31:0] addr1;
  logic        ack1 = 0;
  logic [31:0] data1 = 0;
  logic        stall1 = 1;
  logic [31:0] ins1;
  logic [5:0]  op1;
  logic        valid1;
  logic [31:0] pc1;
  logic [31:0] pcp1;
  logic        err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .SaltoCond(SaltoCond), .Zero(Zero),
    .instru(instru), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst1),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_data(data1),
    .stall(stall1), .SaltoCond(1'b0), .Zero(1'b0),
    .instru(ins1), .opcode(op1),
    .instr_valid(valid1), .pc(pc1),
    .pc_plus4(pcp1), .fetch_err(err1)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one instruction in hand, or waiting
  // for memory with a wait count, or idle for one cycle.
  logic        m_known = 0;
  logic        m_req, m_have, m_err;
  logic [31:0] m_pc, m_ins;
  int          m_wait;

  always @(posedge clk) begin
    int off;
    if (rst) begin
      m_known = 1; m_pc = 0; m_ins = 0;
      m_have = 0; m_req = 0; m_err = 0; m_wait = 0;
    end else if (m_known) begin
      m_err = 0;
      if (m_have) begin
        if (!stall) begin
          off = int'($signed(m_ins[15:0])) * 4;
          m_pc = m_pc + 4;
          if (SaltoCond && Zero) m_pc = m_pc + 32'(off);
          m_have = 0;
          m_req = 1;
        end
      end else if (m_req) begin
        if (imem_ack) begin
          m_ins = imem_data; m_have = 1;
          m_req = 0; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == 15) begin
            m_err = 1; m_req = 0; m_wait = 0;
          end
        end
      end else begin
        m_req = 1;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (m_known) begin
      chk("req", 32'(imem_req), 32'(m_req));
      chk("addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc4", pc_plus4, m_pc + 4);
      chk("valid", 32'(instr_valid), 32'(m_have));
      chk("instru", instru, m_ins);
      chk("opcode", 32'(opcode), 32'(m_ins >> 26));
      chk("ferr", 32'(fetch_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    if (!imem_req) chk("req_timeout", 0, 1);
  endtask

  task automatic fetch(logic [31:0] d, int w);
    wait_req();
    repeat (w) step();
    imem_ack = 1; imem_data = d;
    step();
    imem_ack = 0;
  endtask

  task automatic retire(logic sc, logic z);
    SaltoCond = sc; Zero = z; stall = 0;
    step();
    stall = 1; SaltoCond = 0; Zero = 0;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    // Wrap-around instance
    step(); step();
    rst1 = 0;
    n = 0;
    while (!req1 && n < 20) begin step(); n++; end
    chk("w_addr0", addr1, 32'hFFFF_FFFC);
    ack1 = 1; data1 = 0;
    step();
    ack1 = 0;
    chk("w_valid", 32'(valid1), 1);
    chk("w_pc4", pcp1, 0);
    stall1 = 0;
    step();
    stall1 = 1;
    n = 0;
    while (!req1 && n < 20) begin step(); n++; end
    chk("w_addr1", addr1, 0);

    // Reset and first fetch
    rst = 0;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    fetch(32'h8C22_0004, 0);
    chk("t1_valid", 32'(instr_valid), 1);
    chk("t1_op", 32'(opcode), 32'h23);
    retire(0, 0);
    chk("t1_pc", pc, 4);
    fetch(0, 1); retire(0, 0);
    fetch(0, 2); retire(0, 0);
    fetch(0, 0); retire(0, 0);
    chk("pc10", pc, 32'h10);

    // Taken / not-taken branch
    fetch(32'h1000_FFFF, 0);
    retire(1, 1);
    wait_req();
    chk("br_taken", imem_addr, 32'h10);
    fetch(32'h1000_FFFF, 0);
    retire(1, 0);
    wait_req();
    chk("br_not", imem_addr, 32'h14);

    // Stall holds, branch inputs ignored
    fetch(32'h2002_0005, 1);
    Zero = 1;
    for (int i = 0; i < 5; i++) begin
      SaltoCond = i[0];
      step();
    end
    chk("st_ins", instru, 32'h2002_0005);
    chk("st_pc", pc, 32'h14);
    chk("st_valid", 32'(instr_valid), 1);
    retire(0, 1);
    chk("st_ret", pc, 32'h18);

    // Timeout, retry, then late-boundary ack
    wait_req();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!imem_req) break;
      n++;
    end
    chk("to_cycles", n, 15);
    chk("to_err", 32'(fetch_err), 1);
    step();
    chk("rt_req", 32'(imem_req), 1);
    chk("rt_addr", imem_addr, 32'h18);
    chk("rt_err", 32'(fetch_err), 0);
    fetch(32'h0800_0001, 14);
    chk("bnd_valid", 32'(instr_valid), 1);
    retire(0, 0);

    // Stray ack in ISSUE, then resets
    fetch(32'h1234_5678, 0);
    imem_ack = 1; imem_data = 32'hFFFF_FFFF;
    step();
    imem_ack = 0;
    chk("stray", instru, 32'h1234_5678);
    rst = 1;
    step();
    rst = 0;
    chk("ri_req", 32'(imem_req), 0);
    chk("ri_valid", 32'(instr_valid), 0);
    chk("ri_pc", pc, 0);
    wait_req();
    step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("rf_req", 32'(imem_req), 0);
    chk("rf_pc", pc, 0);
    fetch(32'h8C22_0004, 0);
    retire(0, 0);
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
